// File: rtl/dibit_symbol_mapper.sv
// Splits parallel words into MSB-first dibits and holds each one for SYMBOL_CYCLES clocks on sel1/sel0.
// Define DIBIT_SYMBOL_MAPPER_GRAY_EN for Gray-coded selects; the default build uses natural binary.
module dibit_symbol_mapper #(
  parameter int DATA_WIDTH    = 8,
  parameter int SYMBOL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  sel1,
  output logic                  sel0,
  output logic                  sym_valid,
  output logic                  sym_strobe,
  output logic                  busy
);

  localparam int SYMS   = DATA_WIDTH / 2;
  localparam int IDX_W  = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam int HOLD_W = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nxt, shifted;
  logic [IDX_W-1:0]      sym_idx, sym_idx_nxt;
  logic [HOLD_W-1:0]     hold_cnt, hold_nxt;
  logic [1:0]            sel_nxt;
  logic                  valid_nxt, strobe_nxt;
  logic                  last_sym, last_hold, accept;

  function automatic logic [1:0] map_dibit(input logic [1:0] d);
`ifdef DIBIT_SYMBOL_MAPPER_GRAY_EN
    return {d[1], d[1] ^ d[0]};
`else
    return d;
`endif
  endfunction

  assign last_sym   = (sym_idx == IDX_W'(SYMS - 1));
  assign last_hold  = (hold_cnt == HOLD_W'(SYMBOL_CYCLES - 1));
  // Reset blocks acceptance so a word offered during reset is never taken.
  assign data_ready = !rst && ((state == IDLE) || (last_sym && last_hold));
  assign accept     = data_valid && data_ready;
  assign shifted    = shift_reg << 2;
  assign busy       = sym_valid;

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    sym_idx_nxt = sym_idx;
    hold_nxt    = hold_cnt;
    sel_nxt     = {sel1, sel0};
    valid_nxt   = sym_valid;
    strobe_nxt  = 1'b0;

    if (accept) begin
      // Taking a word from IDLE or from the last cycle of the previous word is identical.
      state_nxt   = SEND;
      shift_nxt   = data_in;
      sym_idx_nxt = '0;
      hold_nxt    = '0;
      sel_nxt     = map_dibit(data_in[DATA_WIDTH-1 -: 2]);
      valid_nxt   = 1'b1;
      strobe_nxt  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          sel_nxt   = 2'b00;
          valid_nxt = 1'b0;
        end
        SEND: begin
          if (!last_hold) begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end else if (!last_sym) begin
            shift_nxt   = shifted;
            sym_idx_nxt = sym_idx + IDX_W'(1);
            hold_nxt    = '0;
            sel_nxt     = map_dibit(shifted[DATA_WIDTH-1 -: 2]);
            strobe_nxt  = 1'b1;
          end else begin
            state_nxt = IDLE;
            sel_nxt   = 2'b00;
            valid_nxt = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      sym_idx    <= '0;
      hold_cnt   <= '0;
      sel1       <= 1'b0;
      sel0       <= 1'b0;
      sym_valid  <= 1'b0;
      sym_strobe <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      sym_idx    <= sym_idx_nxt;
      hold_cnt   <= hold_nxt;
      sel1       <= sel_nxt[1];
      sel0       <= sel_nxt[0];
      sym_valid  <= valid_nxt;
      sym_strobe <= strobe_nxt;
    end
  end

endmodule

// File: tb/tb_dibit_symbol_mapper.sv
// Bench for dibit_symbol_mapper: a default 8-bit/4-cycle instance and a 4-bit/1-cycle instance
// driven side by side and checked every cycle against a transmission-time reference model.
module tb_dibit_symbol_mapper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, dv_a, ready_a, sel1_a, sel0_a, valid_a, strobe_a, busy_a;
  logic [7:0] din_a;
  logic       rst_b, dv_b, ready_b, sel1_b, sel0_b, valid_b, strobe_b, busy_b;
  logic [3:0] din_b;

  dibit_symbol_mapper #(.DATA_WIDTH(8), .SYMBOL_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst_a), .data_in(din_a), .data_valid(dv_a), .data_ready(ready_a),
    .sel1(sel1_a), .sel0(sel0_a), .sym_valid(valid_a), .sym_strobe(strobe_a), .busy(busy_a));

  dibit_symbol_mapper #(.DATA_WIDTH(4), .SYMBOL_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst_b), .data_in(din_b), .data_valid(dv_b), .data_ready(ready_b),
    .sel1(sel1_b), .sel0(sel0_b), .sym_valid(valid_b), .sym_strobe(strobe_b), .busy(busy_b));

  int total = 0;
  int bad   = 0;

  int dw_m [2] = '{8, 4};
  int sc_m [2] = '{4, 1};
  int act  [2] = '{0, 0};
  int t    [2] = '{0, 0};
  int word [2] = '{0, 0};
  int r_in [2];
  int v_in [2];
  int d_in [2];

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int map_ref(input int d);
`ifdef DIBIT_SYMBOL_MAPPER_GRAY_EN
    return (d & 2) | (((d >> 1) ^ d) & 1);
`else
    return d;
`endif
  endfunction

  // The word lasts (DW/2)*SC clocks; t counts clocks since acceptance.
  function automatic int word_len(input int k);
    return (dw_m[k] / 2) * sc_m[k];
  endfunction

  function automatic int exp_ready(input int k);
    if (r_in[k] != 0) return 0;
    return (act[k] == 0 || t[k] == word_len(k) - 1) ? 1 : 0;
  endfunction

  function automatic int exp_sel(input int k);
    if (act[k] == 0) return 0;
    return map_ref((word[k] >> (dw_m[k] - 2 - 2 * (t[k] / sc_m[k]))) & 3);
  endfunction

  task automatic check_inst(input int k);
    logic [5:0] o;
    string      nm;
    nm = (k == 0) ? "a" : "b";
    o  = (k == 0) ? {ready_a, sel1_a, sel0_a, valid_a, strobe_a, busy_a}
                  : {ready_b, sel1_b, sel0_b, valid_b, strobe_b, busy_b};
    checkOutput({nm, ".ready"},  8'(o[5]),   8'(exp_ready(k)));
    checkOutput({nm, ".sel"},    8'(o[4:3]), 8'(exp_sel(k)));
    checkOutput({nm, ".valid"},  8'(o[2]),   8'(act[k]));
    checkOutput({nm, ".strobe"}, 8'(o[1]),   8'((act[k] != 0 && (t[k] % sc_m[k]) == 0) ? 1 : 0));
    checkOutput({nm, ".busy"},   8'(o[0]),   8'(act[k]));
  endtask

  task automatic update_model(input int k);
    int rdy;
    rdy = exp_ready(k);
    if (r_in[k] != 0) begin
      act[k] = 0;
    end else if (v_in[k] != 0 && rdy != 0) begin
      word[k] = d_in[k];
      t[k]    = 0;
      act[k]  = 1;
    end else if (act[k] != 0) begin
      t[k]++;
      if (t[k] == word_len(k)) act[k] = 0;
    end
  endtask

  // One clock: drive at the falling edge, check mid-low phase, then advance the model on the rising edge.
  task automatic applyStimulus(input int ra, input int va, input int da,
                               input int rb, input int vb, input int db);
    @(negedge clk);
    r_in[0] = ra; v_in[0] = va; d_in[0] = da & 8'hFF;
    r_in[1] = rb; v_in[1] = vb; d_in[1] = db & 4'hF;
    rst_a = (ra != 0); dv_a = (va != 0); din_a = 8'(d_in[0]);
    rst_b = (rb != 0); dv_b = (vb != 0); din_b = 4'(d_in[1]);
    #1;
    check_inst(0);
    check_inst(1);
    @(posedge clk);
    update_model(0);
    update_model(1);
  endtask

  initial begin
    rst_a = 1'b1; dv_a = 1'b0; din_a = '0;
    rst_b = 1'b1; dv_b = 1'b0; din_b = '0;
    repeat (2) @(posedge clk);

    $display("[TB] reset");
    repeat (2) applyStimulus(1, 1, 8'hAA, 1, 1, 4'hA);

    $display("[TB] single word 0xB4 / 0x9");
    applyStimulus(0, 1, 8'hB4, 0, 1, 4'h9);
    repeat (20) applyStimulus(0, 0, $urandom, 0, 0, $urandom);

    $display("[TB] back-to-back 0xB4 then 0x1E");
    applyStimulus(0, 1, 8'hB4, 0, 1, 4'h6);
    repeat (16) applyStimulus(0, 1, 8'h1E, 0, 1, 4'hC);
    repeat (20) applyStimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] backpressure with changing data");
    repeat (40) applyStimulus(0, 1, $urandom, 0, 1, $urandom);
    repeat (20) applyStimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] reset mid-word");
    applyStimulus(0, 1, 8'hFF, 0, 1, 4'hF);
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 8'h55, 1, 1, 4'h5);
    applyStimulus(0, 1, 8'h00, 0, 1, 4'h0);
    repeat (20) applyStimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0) ? 1 : 0, $urandom_range(0, 1), $urandom,
                    ($urandom_range(0, 63) == 0) ? 1 : 0, $urandom_range(0, 1), $urandom);
    end
    repeat (20) applyStimulus(0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
